// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit (md_unit, md_compute).
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MADD  = 3'b100,
      MD_MADDU = 3'b101
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W           = 5;

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. madd/maddu return the bare product;
// the accumulate with {hi,lo} happens in md_unit at commit time.
module md_compute
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quo;
   logic [31:0] rem;

   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide via magnitudes: avoids the -2^31 / -1 overflow corner and
   // gives truncation toward zero with the remainder following the dividend.
   always_comb begin
      div_signed = (op == MD_DIV);
      mag_a      = (div_signed && a[31]) ? (~a + 32'd1) : a;
      mag_b      = (div_signed && b[31]) ? (~b + 32'd1) : b;
      divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
      uq         = mag_a / divisor;
      ur         = mag_a % divisor;
      quo        = (div_signed && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
      rem        = (div_signed && a[31]) ? (~ur + 32'd1) : ur;
   end

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      div0   = 1'b0;
      case (op)
         MD_MULT, MD_MADD: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU, MD_MADDU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV, MD_DIVU: begin
            res_hi = rem;
            res_lo = quo;
            div0   = (b == 32'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// MIPS HI/LO multiply/divide responder with fixed-latency busy window.
// Optional madd/maddu accumulate enabled by defining MD_MADD_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation in flight; mthi/mtlo honoured, starts accepted
// ST_RUN  | busy=1, counter counting down; commit to hi/lo at count==1
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t        state_q;
   md_state_t        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_load;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_div0;
   logic             pend_acc;
   logic             op_valid;
   logic             start_ok;
   logic             commit;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_div0;
   logic [63:0]      commit_val;

`ifdef MD_MADD_EN
   assign op_valid = (md_op <= MD_MADDU);
`else
   assign op_valid = (md_op <= MD_DIVU);
`endif

   assign cnt_load = op_is_div(md_op) ? DIV_CYCLES[CNT_W-1:0] : MULT_CYCLES[CNT_W-1:0];

   md_compute u_compute (
      .op     (md_op),
      .a      (src_a),
      .b      (src_b),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .div0   (res_div0)
   );

`ifdef MD_MADD_EN
   // Accumulator is read at commit so an older mthi/mtlo is folded in correctly.
   assign commit_val = pend_acc ? ({hi_q, lo_q} + {pend_hi, pend_lo}) : {pend_hi, pend_lo};
`else
   assign commit_val = {pend_hi, pend_lo};
`endif

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      commit   = 1'b0;
      busy     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (md_start && op_valid) begin
               start_ok = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_div0 <= 1'b0;
         pend_acc  <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            cnt_q     <= cnt_load;
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_div0 <= res_div0;
            pend_acc  <= (md_op == MD_MADD) || (md_op == MD_MADDU);
         end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (commit) begin
            if (!pend_div0) begin
               hi_q <= commit_val[63:32];
               lo_q <= commit_val[31:0];
            end
         end else if (state_q == ST_IDLE && !start_ok) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected hi/lo/busy-length queued at issue, checked at completion.
module tb_md_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   md_unit dut (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start),
      .md_op    (md_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .wdata    (wdata),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int n);
      @(negedge clk);
      md_start = 1'b1; md_op = op; src_a = a; src_b = b;
      sb.push_back('{eh, el, n});
      @(negedge clk);
      md_start = 1'b0;
   endtask

   // Called at a negedge inside the busy window; already_seen counts earlier busy cycles.
   task automatic wait_done(input string tag, input int already_seen);
      int   cnt;
      exp_t e;
      cnt = already_seen;
      while (busy === 1'b1 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_busy_cycles"}, 64'(cnt), 64'(e.n));
         check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
         check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
   endtask

   task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
      @(negedge clk);
      hi_we = whi; lo_we = wlo; wdata = d;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   task automatic try_reserved(input string tag, input logic [2:0] op);
      @(negedge clk);
      md_start = 1'b1; md_op = op; src_a = 32'd9; src_b = 32'd9;
      @(negedge clk);
      md_start = 1'b0;
      check(tag, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; md_start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);

      issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
      wait_done("mult", 0);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
      wait_done("multu", 0);

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_done("div_neg", 0);

      write_hilo(1'b0, 1'b1, 32'h0000_1234);
      check("mtlo_lo", {32'd0, lo}, 64'h1234);
      check("mtlo_hi_kept", {32'd0, hi}, 64'hFFFF_FFFF);

      issue(MD_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 10);
      wait_done("divu_by0", 0);

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
      wait_done("div_ovf", 0);

      issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      wait_done("divu", 0);

      // Deliberate upstream protocol violation: new start plus mthi while busy.
      issue(MD_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 5);
      $display("note: injecting md_start and hi_we while busy (protocol violation)");
      md_start = 1'b1; md_op = MD_MULT; src_a = 32'd7; src_b = 32'd7;
      hi_we = 1'b1; wdata = 32'h0000_DEAD;
      @(negedge clk);
      md_start = 1'b0; hi_we = 1'b0;
      wait_done("busy_ignore", 1);

      try_reserved("reserved_110", 3'b110);
      try_reserved("reserved_111", 3'b111);
`ifndef MD_MADD_EN
      try_reserved("reserved_madd", 3'b100);
`endif

      write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
      check("mthilo_hi", {32'd0, hi}, 64'hCAFE_F00D);
      check("mthilo_lo", {32'd0, lo}, 64'hCAFE_F00D);

      // Reset during the 3rd busy cycle aborts the operation.
      issue(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hi", {32'd0, hi}, 64'd0);
      check("abort_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      check("abort_stays_idle", {63'd0, busy}, 64'd0);

`ifdef MD_MADD_EN
      write_hilo(1'b0, 1'b1, 32'd5);
      issue(MD_MADD, 32'd3, 32'd4, 32'd0, 32'd17, 5);
      wait_done("madd", 0);
      issue(MD_MADDU, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'h0000_000F, 5);
      wait_done("maddu", 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
